// File: rtl/arm_pkg.sv
// Shared ARM core definitions: condition codes, flag indices and the
// decode-to-execute control bundle.
package arm_pkg;

  localparam int COND_W = 4;
  localparam int FLAG_W = 4;

  typedef enum logic [COND_W-1:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    cond_e      cond;
  } ctrl_de_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: {cond, flags} -> cond_ex.
module cond_check
  import arm_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    // NOTE: default assigned first so no path leaves cond_ex unassigned (no latch).
    cond_ex = 1'b1;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_cond_stage.sv
// Execute-stage control register, NZCV flags register and condition-gated
// write/branch/PC controls.
module execute_cond_stage
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushE,
  input  logic              PCSD,
  input  logic              RegWD,
  input  logic              MemWD,
  input  logic              BranchD,
  input  logic              MemtoRegD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ALUControlD,
  input  logic [1:0]        FlagWD,
  input  logic [COND_W-1:0] CondD,
  input  logic [FLAG_W-1:0] ALUFlags,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              BranchTakenE,
  output logic              MemtoRegE,
  output logic              ALUSrcE,
  output logic [1:0]        ALUControlE,
  output logic              CondExE,
  output logic [FLAG_W-1:0] FlagsE
);

  ctrl_de_t          ctrl_d;
  ctrl_de_t          ctrl_e;
  logic [FLAG_W-1:0] flags;

  assign ctrl_d = '{
    pcs:         PCSD,
    reg_w:       RegWD,
    mem_w:       MemWD,
    branch:      BranchD,
    mem_to_reg:  MemtoRegD,
    alu_src:     ALUSrcD,
    alu_control: ALUControlD,
    flag_w:      FlagWD,
    cond:        cond_e'(CondD)
  };

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset)       ctrl_e <= '0;
    else if (FlushE) ctrl_e <= '0;
    else             ctrl_e <= ctrl_d;
  end

  cond_check u_cond_check (
    .cond    (ctrl_e.cond),
    .flags   (flags),
    .cond_ex (CondExE)
  );

  // Flag write uses the instruction currently in E, independent of FlushE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else begin
      if (ctrl_e.flag_w[FW_NZ] && CondExE)
        flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (ctrl_e.flag_w[FW_CV] && CondExE)
        flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign PCSrcE       = ctrl_e.pcs    & CondExE;
  assign RegWriteE    = ctrl_e.reg_w  & CondExE;
  assign MemWriteE    = ctrl_e.mem_w  & CondExE;
  assign BranchTakenE = ctrl_e.branch & CondExE;
  assign MemtoRegE    = ctrl_e.mem_to_reg;
  assign ALUSrcE      = ctrl_e.alu_src;
  assign ALUControlE  = ctrl_e.alu_control;
  assign FlagsE       = flags;

endmodule
